// File: rtl/smi_axi_read_tag_manager.sv
// SMI-to-AXI read tag manager: allocates AXI IDs from a free pool, issues AR bursts and emits
// one response descriptor per burst. Define SMI_AXI_READ_ID_CHECK_EN to discard beats on idle IDs.
module smi_axi_read_tag_manager #(
    parameter int DataIndexSize = 3,
    parameter int AxiIdWidth    = 4,
    parameter int MaxIds        = 4
) (
    input  logic                  clk,
    input  logic                  srstN,
    input  logic                  reqValid,
    input  logic [15:0]           reqTag,
    input  logic [63:0]           reqAddr,
    input  logic [15:0]           reqLength,
    input  logic                  reqNoCache,
    output logic                  reqStop,
    output logic                  axiARValid,
    input  logic                  axiARReady,
    output logic [AxiIdWidth-1:0] axiARId,
    output logic [63:0]           axiARAddr,
    output logic [7:0]            axiARLen,
    output logic [2:0]            axiARSize,
    output logic [3:0]            axiARCache,
    input  logic                  rBeatValid,
    input  logic [AxiIdWidth-1:0] rBeatId,
    input  logic [1:0]            rBeatResp,
    input  logic                  rBeatLast,
    output logic                  rBeatStop,
    output logic                  descValid,
    input  logic                  descStop,
    output logic [15:0]           descTag,
    output logic [7:0]            descOffset,
    output logic [15:0]           descLength,
    output logic [1:0]            descStatus,
    output logic [AxiIdWidth:0]   outstanding
`ifdef SMI_AXI_READ_ID_CHECK_EN
    ,
    output logic                  spuriousId
`endif
);

    localparam int NumIdSlots = 1 << AxiIdWidth;
    localparam int PtrW       = (MaxIds > 1) ? $clog2(MaxIds) : 1;
    localparam int CntW       = $clog2(MaxIds + 1);
    localparam int OutW       = AxiIdWidth + 1;

    // Free-ID pool
    logic [AxiIdWidth-1:0] r_pool [MaxIds];
    logic [PtrW-1:0]       r_wr_ptr;
    logic [PtrW-1:0]       r_rd_ptr;
    logic [CntW-1:0]       r_count;
    logic [OutW-1:0]       r_init_cnt;
    logic                  r_init_done;

    // Per-ID request context captured at dispatch
    logic [15:0] r_cache_tag [NumIdSlots];
    logic [7:0]  r_cache_off [NumIdSlots];
    logic [15:0] r_cache_len [NumIdSlots];
    logic [NumIdSlots-1:0] r_started;

    logic                  r_ar_valid;
    logic [AxiIdWidth-1:0] r_ar_id;
    logic [63:0]           r_ar_addr;
    logic [7:0]            r_ar_len;
    logic [3:0]            r_ar_cache;

    logic        r_desc_valid;
    logic [15:0] r_desc_tag;
    logic [7:0]  r_desc_off;
    logic [15:0] r_desc_len;
    logic [1:0]  r_desc_status;

    logic                  w_req_acc;
    logic                  w_push;
    logic [AxiIdWidth-1:0] w_push_id;
    logic [AxiIdWidth-1:0] w_pop_id;
    logic                  w_beat_first;
    logic                  w_desc_free;
    logic                  w_spurious;
    logic                  w_beat_acc;
    logic                  w_release;
    logic [15:0]           w_addr_lo;
    logic [7:0]            w_ar_len;

`ifdef SMI_AXI_READ_ID_CHECK_EN
    logic [NumIdSlots-1:0] r_busy;
    logic                  r_spurious;
    assign w_spurious = (OutW'(rBeatId) >= OutW'(MaxIds)) | ~r_busy[rBeatId];
    assign spuriousId = r_spurious;
`else
    assign w_spurious = 1'b0;
`endif

    assign w_pop_id  = r_pool[r_rd_ptr];
    assign reqStop   = ~(r_init_done & (r_count != '0) & ~r_ar_valid);
    assign w_req_acc = reqValid & ~reqStop;

    // Only a first beat needs the descriptor register; continuation beats always flow.
    assign w_beat_first = ~r_started[rBeatId];
    assign w_desc_free  = ~r_desc_valid | ~descStop;
    assign rBeatStop    = ~r_init_done | (~w_spurious & w_beat_first & ~w_desc_free);
    assign w_beat_acc   = rBeatValid & ~rBeatStop & ~w_spurious;
    assign w_release    = w_beat_acc & rBeatLast;

    assign w_push    = ~r_init_done | w_release;
    assign w_push_id = r_init_done ? rBeatId : r_init_cnt[AxiIdWidth-1:0];

    assign w_addr_lo = 16'(reqAddr[DataIndexSize-1:0]);
    assign w_ar_len  = 8'((reqLength - 16'd1 + w_addr_lo) >> DataIndexSize);

    assign axiARValid  = r_ar_valid;
    assign axiARId     = r_ar_id;
    assign axiARAddr   = r_ar_addr;
    assign axiARLen    = r_ar_len;
    assign axiARSize   = 3'(DataIndexSize);
    assign axiARCache  = r_ar_cache;
    assign descValid   = r_desc_valid;
    assign descTag     = r_desc_tag;
    assign descOffset  = r_desc_off;
    assign descLength  = r_desc_len;
    assign descStatus  = r_desc_status;
    assign outstanding = r_init_done ? (OutW'(MaxIds) - OutW'(r_count)) : '0;

    // Storage arrays carry no reset; pointers and started bits define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pool[r_wr_ptr] <= w_push_id;
        end
        if (w_req_acc) begin
            r_cache_tag[w_pop_id] <= reqTag;
            r_cache_off[w_pop_id] <= reqAddr[7:0];
            r_cache_len[w_pop_id] <= reqLength;
        end
    end

    always_ff @(posedge clk) begin
        if (!srstN) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_init_cnt    <= '0;
            r_init_done   <= 1'b0;
            r_started     <= '0;
            r_ar_valid    <= 1'b0;
            r_ar_id       <= '0;
            r_ar_addr     <= '0;
            r_ar_len      <= '0;
            r_ar_cache    <= 4'b0010;
            r_desc_valid  <= 1'b0;
            r_desc_tag    <= '0;
            r_desc_off    <= '0;
            r_desc_len    <= '0;
            r_desc_status <= '0;
        end else begin
            if (!r_init_done) begin
                r_init_cnt <= r_init_cnt + OutW'(1);
                if (r_init_cnt == OutW'(MaxIds - 1)) begin
                    r_init_done <= 1'b1;
                end
            end

            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PtrW'(MaxIds - 1)) ? '0 : r_wr_ptr + PtrW'(1);
            end
            if (w_req_acc) begin
                r_rd_ptr <= (r_rd_ptr == PtrW'(MaxIds - 1)) ? '0 : r_rd_ptr + PtrW'(1);
            end
            if (w_push && !w_req_acc) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_push && w_req_acc) begin
                r_count <= r_count - CntW'(1);
            end

            if (w_req_acc) begin
                r_ar_valid <= 1'b1;
                r_ar_id    <= w_pop_id;
                r_ar_addr  <= reqAddr;
                r_ar_len   <= w_ar_len;
                r_ar_cache <= {3'b001, ~reqNoCache};
            end else if (axiARReady) begin
                r_ar_valid <= 1'b0;
            end

            if (w_beat_acc) begin
                if (rBeatLast) begin
                    r_started[rBeatId] <= 1'b0;
                end else if (w_beat_first) begin
                    r_started[rBeatId] <= 1'b1;
                end
            end

            if (w_beat_acc && w_beat_first) begin
                r_desc_valid  <= 1'b1;
                r_desc_tag    <= r_cache_tag[rBeatId];
                r_desc_off    <= r_cache_off[rBeatId];
                r_desc_len    <= r_cache_len[rBeatId];
                r_desc_status <= rBeatResp;
            end else if (!descStop) begin
                r_desc_valid <= 1'b0;
            end
        end
    end

`ifdef SMI_AXI_READ_ID_CHECK_EN
    always_ff @(posedge clk) begin
        if (!srstN) begin
            r_busy     <= '0;
            r_spurious <= 1'b0;
        end else begin
            if (w_req_acc) begin
                r_busy[w_pop_id] <= 1'b1;
            end
            if (w_release) begin
                r_busy[rBeatId] <= 1'b0;
            end
            r_spurious <= rBeatValid & ~rBeatStop & w_spurious;
        end
    end
`endif

endmodule

// File: tb/tb_smi_axi_read_tag_manager.sv
// Randomized bench for smi_axi_read_tag_manager against a queue-based model of the ID pool,
// AR slot and descriptor stage; also covers reset values, pool exhaustion and mid-run reset.
module tb_smi_axi_read_tag_manager;

    localparam int DIS   = 3;
    localparam int IDW   = 4;
    localparam int MAXID = 4;
    localparam int NSLOT = 1 << IDW;
    localparam int NCYC  = 4000;

    logic            clk = 1'b0;
    logic            srstN = 1'b0;
    logic            reqValid, reqNoCache, reqStop;
    logic [15:0]     reqTag, reqLength;
    logic [63:0]     reqAddr;
    logic            axiARValid, axiARReady;
    logic [IDW-1:0]  axiARId;
    logic [63:0]     axiARAddr;
    logic [7:0]      axiARLen;
    logic [2:0]      axiARSize;
    logic [3:0]      axiARCache;
    logic            rBeatValid, rBeatLast, rBeatStop;
    logic [IDW-1:0]  rBeatId;
    logic [1:0]      rBeatResp;
    logic            descValid, descStop;
    logic [15:0]     descTag, descLength;
    logic [7:0]      descOffset;
    logic [1:0]      descStatus;
    logic [IDW:0]    outstanding;
    logic            spuriousId;

    smi_axi_read_tag_manager #(
        .DataIndexSize(DIS), .AxiIdWidth(IDW), .MaxIds(MAXID)
    ) dut (
        .clk(clk), .srstN(srstN),
        .reqValid(reqValid), .reqTag(reqTag), .reqAddr(reqAddr), .reqLength(reqLength),
        .reqNoCache(reqNoCache), .reqStop(reqStop),
        .axiARValid(axiARValid), .axiARReady(axiARReady), .axiARId(axiARId),
        .axiARAddr(axiARAddr), .axiARLen(axiARLen), .axiARSize(axiARSize),
        .axiARCache(axiARCache),
        .rBeatValid(rBeatValid), .rBeatId(rBeatId), .rBeatResp(rBeatResp),
        .rBeatLast(rBeatLast), .rBeatStop(rBeatStop),
        .descValid(descValid), .descStop(descStop), .descTag(descTag),
        .descOffset(descOffset), .descLength(descLength), .descStatus(descStatus),
        .outstanding(outstanding)
`ifdef SMI_AXI_READ_ID_CHECK_EN
        , .spuriousId(spuriousId)
`endif
    );

`ifndef SMI_AXI_READ_ID_CHECK_EN
    assign spuriousId = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          free_q[$];
    bit          inflight[NSLOT];
    bit          issued[NSLOT];
    bit          started[NSLOT];
    int          rem[NSLOT];
    logic [15:0] c_tag[NSLOT];
    logic [7:0]  c_off[NSLOT];
    logic [15:0] c_len[NSLOT];
    bit          m_ar_valid;
    int          m_ar_id, m_ar_len;
    logic [63:0] m_ar_addr;
    logic [3:0]  m_ar_cache;
    bit          m_desc_valid;
    logic [15:0] m_desc_tag, m_desc_len;
    logic [7:0]  m_desc_off;
    logic [1:0]  m_desc_status;
    bit          m_spur;
    int          n_edges;
    bit          first_req;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        reqValid = 1'b0; reqTag = '0; reqAddr = '0; reqLength = 16'd1; reqNoCache = 1'b0;
        axiARReady = 1'b0; rBeatValid = 1'b0; rBeatId = '0; rBeatResp = '0;
        rBeatLast = 1'b0; descStop = 1'b0;
    endtask

    task automatic model_reset();
        free_q = {};
        for (int i = 0; i < MAXID; i++) free_q.push_back(i);
        for (int i = 0; i < NSLOT; i++) begin
            inflight[i] = 0; issued[i] = 0; started[i] = 0; rem[i] = 0;
        end
        m_ar_valid = 0; m_desc_valid = 0; m_spur = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        srstN = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_reqStop", reqStop, 1);
        check_val("rst_arValid", axiARValid, 0);
        check_val("rst_arLen", axiARLen, 0);
        check_val("rst_arAddr", axiARAddr, 0);
        check_val("rst_arId", axiARId, 0);
        check_val("rst_arSize", axiARSize, DIS);
        check_val("rst_arCache", axiARCache, 4'b0010);
        check_val("rst_rBeatStop", rBeatStop, 1);
        check_val("rst_descValid", descValid, 0);
        check_val("rst_descFields", {descTag, descOffset, descLength, descStatus}, 0);
        check_val("rst_outstanding", outstanding, 0);
        check_val("rst_spurious", spuriousId, 0);
        model_reset();
        srstN = 1'b1;
        n_edges = 1;   // the edge right after release is the first init cycle
        first_req = 1;
    endtask

    initial begin
        int          cand[$];
        int          id, lo, exp_beats;
        bit          init_done, exp_req_stop, exp_bstop, is_spur;
        bit          ar_hs, req_acc, beat_acc;
        logic [63:0] a;

        drive_idle();
        do_reset();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc == NCYC / 2) do_reset();
            @(negedge clk);
            init_done = (n_edges >= MAXID);

            // Request stimulus; the first request after reset is a fixed unaligned case
            if (first_req) begin
                reqValid = 1'b1; reqAddr = 64'h1003; reqLength = 16'd16;
                reqNoCache = 1'b0; reqTag = 16'hA5C3;
            end else begin
                reqValid = ($urandom_range(0, 2) != 0);
                a = {$urandom, $urandom};
                reqAddr = a;
                lo = int'(a[DIS-1:0]);
                reqLength = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1, (256 << DIS) - lo))
                                                        : 16'($urandom_range(1, 40));
                reqNoCache = 1'($urandom_range(0, 1));
                reqTag = 16'($urandom);
            end
            axiARReady = ($urandom_range(0, 3) != 0);
            descStop = ((cyc % 300) > 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);

            // Beat stimulus: quiet stretches let the pool run dry
            rBeatValid = 1'b0; rBeatId = '0; rBeatLast = 1'b0; rBeatResp = '0;
            cand = {};
            for (int i = 0; i < NSLOT; i++) if (issued[i] && rem[i] > 0) cand.push_back(i);
            if ((cyc % 500) >= 120 && cand.size() > 0 && $urandom_range(0, 2) != 0) begin
                id = cand[$urandom_range(0, cand.size() - 1)];
                rBeatValid = 1'b1; rBeatId = IDW'(id); rBeatLast = (rem[id] == 1);
                rBeatResp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end
`ifdef SMI_AXI_READ_ID_CHECK_EN
            else if (init_done && $urandom_range(0, 11) == 0) begin
                id = $urandom_range(0, NSLOT - 1);
                if (!inflight[id]) begin
                    rBeatValid = 1'b1; rBeatId = IDW'(id);
                    rBeatLast = 1'($urandom_range(0, 1)); rBeatResp = 2'($urandom_range(0, 3));
                end
            end
`endif
            #1;

            // Expected observable behaviour in this cycle
            exp_req_stop = !(init_done && free_q.size() > 0 && !m_ar_valid);
            check_val("reqStop", reqStop, exp_req_stop);
            check_val("outstanding", outstanding, init_done ? MAXID - free_q.size() : 0);
            check_val("arValid", axiARValid, m_ar_valid);
            if (m_ar_valid) begin
                check_val("arId", axiARId, m_ar_id);
                check_val("arAddr", axiARAddr, m_ar_addr);
                check_val("arLen", axiARLen, m_ar_len);
                check_val("arCache", axiARCache, m_ar_cache);
                check_val("arSize", axiARSize, DIS);
            end
            check_val("descValid", descValid, m_desc_valid);
            if (m_desc_valid) begin
                check_val("descTag", descTag, m_desc_tag);
                check_val("descOffset", descOffset, m_desc_off);
                check_val("descLength", descLength, m_desc_len);
                check_val("descStatus", descStatus, m_desc_status);
            end
`ifdef SMI_AXI_READ_ID_CHECK_EN
            check_val("spuriousId", spuriousId, m_spur);
`endif
            is_spur = 0;
            exp_bstop = 0;
            if (rBeatValid) begin
                id = int'(rBeatId);
`ifdef SMI_AXI_READ_ID_CHECK_EN
                is_spur = (id >= MAXID) || !inflight[id];
`endif
                if (!init_done) exp_bstop = 1;
                else if (is_spur) exp_bstop = 0;
                else exp_bstop = !started[id] && m_desc_valid && descStop;
                check_val("rBeatStop", rBeatStop, exp_bstop);
            end

            // Advance the model across the coming clock edge
            ar_hs    = m_ar_valid && axiARReady;
            req_acc  = reqValid && !exp_req_stop;
            beat_acc = rBeatValid && !exp_bstop && !is_spur;
            m_spur   = rBeatValid && !exp_bstop && is_spur;

            if (m_desc_valid && !descStop)
                $display("DESC tag=%h off=%h len=%0d status=%0d", m_desc_tag, m_desc_off,
                         m_desc_len, m_desc_status);
            if (ar_hs) begin
                $display("AR   id=%0d addr=%h len=%0d cache=%b", m_ar_id, m_ar_addr, m_ar_len, m_ar_cache);
                issued[m_ar_id] = 1;
                rem[m_ar_id] = m_ar_len + 1;
                m_ar_valid = 0;
            end
            if (req_acc) begin
                id = free_q.pop_front();
                inflight[id] = 1; issued[id] = 0;
                c_tag[id] = reqTag; c_off[id] = reqAddr[7:0]; c_len[id] = reqLength;
                exp_beats = (int'(reqAddr[DIS-1:0]) + int'(reqLength) + (1 << DIS) - 1) / (1 << DIS);
                m_ar_valid = 1; m_ar_id = id; m_ar_addr = reqAddr;
                m_ar_len = (exp_beats - 1) & 255;
                m_ar_cache = reqNoCache ? 4'b0010 : 4'b0011;
                first_req = 0;
            end
            if (beat_acc) begin
                id = int'(rBeatId);
                if (!started[id]) begin
                    m_desc_valid = 1; m_desc_tag = c_tag[id]; m_desc_off = c_off[id];
                    m_desc_len = c_len[id]; m_desc_status = rBeatResp;
                    started[id] = 1;
                end else if (!descStop) begin
                    m_desc_valid = 0;
                end
                rem[id]--;
                if (rem[id] == 0) begin
                    started[id] = 0; inflight[id] = 0; issued[id] = 0;
                    free_q.push_back(id);
                end
            end else if (!descStop) begin
                m_desc_valid = 0;
            end
            if (n_edges < 1000) n_edges++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
